// File: rtl/mac_array_sequencer.sv
// Sequencing controller for the MAC array. It clears the accumulators, steps the
// reduction index k with a load pulse per valid operand pair, then strobes the result write.
module mac_array_sequencer #(
    parameter int N  = 3,
    parameter int KW = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          abort,
    input  logic          op_valid,
    output logic [KW-1:0] k,
    output logic          mac_clear,
    output logic          mac_load,
    output logic          res_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    state_t        state_r;
    state_t        state_s;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_s;
    logic          mac_clear_r;
    logic          res_we_r;
    logic          busy_r;
    logic          done_r;

    // Next-state and next-k decode; abort in any active state returns to IDLE.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        case (state_r)
            IDLE: begin
                k_s = {KW{1'b0}};
                if (start && !abort) begin
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                k_s = {KW{1'b0}};
                if (abort) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_s = IDLE;
                    k_s     = {KW{1'b0}};
                end else if (op_valid) begin
                    if (k_r == K_LAST) begin
                        state_s = DRAIN;
                        k_s     = {KW{1'b0}};
                    end else begin
                        state_s = ACCUM;
                        k_s     = k_r + K_ONE;
                    end
                end else begin
                    state_s = ACCUM;
                    k_s     = k_r;
                end
            end
            DRAIN: begin
                k_s = {KW{1'b0}};
                if (abort) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                k_s     = {KW{1'b0}};
                state_s = IDLE;
            end
            default: begin
                k_s     = {KW{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // State, index and Moore outputs; outputs are decoded from the next state so they
    // leave the register aligned with the state they describe.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r     <= IDLE;
            k_r         <= {KW{1'b0}};
            mac_clear_r <= 1'b0;
            res_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            mac_clear_r <= (state_s == CLEAR);
            res_we_r    <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
        end
    end

    // The load line follows op_valid directly so a stalled cycle never accumulates.
    assign mac_load  = (state_r == ACCUM) && op_valid;
    assign k         = k_r;
    assign mac_clear = mac_clear_r;
    assign res_we    = res_we_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
